// File: rtl/jt51_seq_pkg.sv
// Shared constants and slot-to-group decode for the jt51 accumulator slot sequencer.
package jt51_seq_pkg;

  localparam int SLOTS = 32;

  localparam logic [1:0] GRP_M1 = 2'd0;
  localparam logic [1:0] GRP_M2 = 2'd1;
  localparam logic [1:0] GRP_C1 = 2'd2;
  localparam logic [1:0] GRP_C2 = 2'd3;

  // One-hot {c2, c1, m2, m1}; the group is the upper two bits of the slot.
  function automatic logic [3:0] grp_onehot(input logic [4:0] slot);
    logic [3:0] oh;
    oh = 4'b0000;
    case (slot[4:3])
      GRP_M1:  oh = 4'b0001;
      GRP_M2:  oh = 4'b0010;
      GRP_C1:  oh = 4'b0100;
      GRP_C2:  oh = 4'b1000;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/jt51_frame_hs.sv
// Valid/ready handshake for finished stereo frames, with a sticky overrun flag.
module jt51_frame_hs (
  input  logic clk,
  input  logic rst,
  input  logic frame_end_next,
  input  logic sample_ready,
  input  logic ovr_clr,
  output logic sample_valid,
  output logic overrun
);

  logic accept;
  logic ovr_set;
  logic valid_next;
  logic overrun_next;

  always_comb begin
    accept       = sample_valid & sample_ready;
    ovr_set      = frame_end_next & sample_valid & ~sample_ready;
    valid_next   = sample_valid;
    overrun_next = overrun;
    if (frame_end_next) begin
      valid_next = 1'b1;
    end else if (accept) begin
      valid_next = 1'b0;
    end
    // A fresh overrun takes priority over a clear landing on the same edge.
    if (ovr_set) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= valid_next;
      overrun      <= overrun_next;
    end
  end

endmodule

// File: rtl/jt51_acc_seq.sv
// 32-slot operator cycle sequencer: group strobes, channel index, op31 flag and frame handshake.
module jt51_acc_seq
  import jt51_seq_pkg::*;
#(
  parameter int OFFSET    = 0,
  parameter int OP31_SLOT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       sync,
  input  logic       sample_ready,
  input  logic       ovr_clr,
  output logic [4:0] cnt,
  output logic [2:0] ch,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       op31_acc,
  output logic       frame_end,
  output logic       sample_valid,
  output logic       overrun
);

  localparam logic [4:0] OFF       = 5'(OFFSET);
  localparam logic [4:0] OP31      = 5'(OP31_SLOT);
  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [4:0] ACNT_RST  = 5'd0 - OFF;

  logic [4:0] cnt_next;
  logic [4:0] acnt;
  logic [4:0] acnt_next;
  logic [3:0] grp_next;
  logic [3:0] grp_rst;
  logic       frame_end_next;

  // Strobes load the decode of the next accumulator slot so they track the visible cnt.
  always_comb begin
    cnt_next       = sync ? 5'd0 : cnt + 5'd1;
    acnt           = cnt - OFF;
    acnt_next      = cnt_next - OFF;
    grp_next       = grp_onehot(acnt_next);
    grp_rst        = grp_onehot(ACNT_RST);
    frame_end_next = cen & (acnt == LAST_SLOT) & (acnt_next == 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 5'd0;
      ch        <= ACNT_RST[2:0];
      m1_enters <= grp_rst[0];
      m2_enters <= grp_rst[1];
      c1_enters <= grp_rst[2];
      c2_enters <= grp_rst[3];
      op31_acc  <= (ACNT_RST == OP31);
      frame_end <= 1'b0;
    end else if (cen) begin
      cnt       <= cnt_next;
      ch        <= acnt_next[2:0];
      m1_enters <= grp_next[0];
      m2_enters <= grp_next[1];
      c1_enters <= grp_next[2];
      c2_enters <= grp_next[3];
      op31_acc  <= (acnt_next == OP31);
      frame_end <= frame_end_next;
    end
  end

  jt51_frame_hs u_frame_hs (
    .clk            (clk),
    .rst            (rst),
    .frame_end_next (frame_end_next),
    .sample_ready   (sample_ready),
    .ovr_clr        (ovr_clr),
    .sample_valid   (sample_valid),
    .overrun        (overrun)
  );

endmodule

// File: tb/tb_jt51_acc_seq.sv
// Bench for jt51_acc_seq: two instances (OFFSET 0 and 3) checked against an arithmetic slot model.
module tb_jt51_acc_seq;

  logic clk = 1'b0;
  logic rst, cen, sync, sample_ready, ovr_clr;

  logic [1:0][4:0] cnt_o;
  logic [1:0][2:0] ch_o;
  logic [1:0]      m1_o, m2_o, c1_o, c2_o, op_o, fe_o, sv_o, ov_o;

  int vectors     = 0;
  int miscompares = 0;

  int mcnt;
  int m_fe  [2];
  int m_val [2];
  int m_ovr [2];

  always #5 clk = ~clk;

  jt51_acc_seq #(.OFFSET(0), .OP31_SLOT(31)) dut0 (
    .clk(clk), .rst(rst), .cen(cen), .sync(sync),
    .sample_ready(sample_ready), .ovr_clr(ovr_clr),
    .cnt(cnt_o[0]), .ch(ch_o[0]),
    .m1_enters(m1_o[0]), .m2_enters(m2_o[0]), .c1_enters(c1_o[0]), .c2_enters(c2_o[0]),
    .op31_acc(op_o[0]), .frame_end(fe_o[0]),
    .sample_valid(sv_o[0]), .overrun(ov_o[0])
  );

  jt51_acc_seq #(.OFFSET(3), .OP31_SLOT(31)) dut3 (
    .clk(clk), .rst(rst), .cen(cen), .sync(sync),
    .sample_ready(sample_ready), .ovr_clr(ovr_clr),
    .cnt(cnt_o[1]), .ch(ch_o[1]),
    .m1_enters(m1_o[1]), .m2_enters(m2_o[1]), .c1_enters(c1_o[1]), .c2_enters(c2_o[1]),
    .op31_acc(op_o[1]), .frame_end(fe_o[1]),
    .sample_valid(sv_o[1]), .overrun(ov_o[1])
  );

  function automatic int off_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int acnt_of(input int c, input int k);
    return (c - off_of(k) + 32) % 32;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[off%0d] observed=%0d expected=%0d", tag, off_of(k), obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int a;
      a = acnt_of(mcnt, k);
      chk("cnt",          k, 32'(cnt_o[k]), 32'(mcnt));
      chk("ch",           k, 32'(ch_o[k]),  32'(a % 8));
      chk("m1_enters",    k, 32'(m1_o[k]),  32'(a < 8));
      chk("m2_enters",    k, 32'(m2_o[k]),  32'(a >= 8 && a < 16));
      chk("c1_enters",    k, 32'(c1_o[k]),  32'(a >= 16 && a < 24));
      chk("c2_enters",    k, 32'(c2_o[k]),  32'(a >= 24));
      chk("op31_acc",     k, 32'(op_o[k]),  32'(a == 31));
      chk("frame_end",    k, 32'(fe_o[k]),  32'(m_fe[k]));
      chk("sample_valid", k, 32'(sv_o[k]),  32'(m_val[k]));
      chk("overrun",      k, 32'(ov_o[k]),  32'(m_ovr[k]));
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_fe[k] = 0; m_val[k] = 0; m_ovr[k] = 0;
    end
  endtask

  // One clock edge of the reference: slot arithmetic, then per-instance frame handshake.
  task automatic model_edge();
    int newc;
    int fe_new [2];
    if (rst) begin
      model_reset();
      return;
    end
    newc = sync ? 0 : (mcnt + 1) % 32;
    for (int k = 0; k < 2; k++)
      fe_new[k] = (cen && acnt_of(mcnt, k) == 31 && acnt_of(newc, k) == 0) ? 1 : 0;
    if (cen) begin
      mcnt = newc;
      for (int k = 0; k < 2; k++) m_fe[k] = fe_new[k];
    end
    for (int k = 0; k < 2; k++) begin
      bit set_ovr;
      set_ovr = fe_new[k] != 0 && m_val[k] != 0 && !sample_ready;
      if (fe_new[k] != 0)                  m_val[k] = 1;
      else if (m_val[k] != 0 && sample_ready) m_val[k] = 0;
      if (set_ovr)      m_ovr[k] = 1;
      else if (ovr_clr) m_ovr[k] = 0;
    end
  endtask

  task automatic step(input logic c, input logic s, input logic r, input logic o);
    cen = c; sync = s; sample_ready = r; ovr_clr = o;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; sync = 1'b0; sample_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    rst = 1'b0;

    // Free run with OFFSET 0 and 3 side by side, consumer always ready.
    for (int i = 0; i < 31; i++) step(1, 0, 1, 0);
    chk("cnt_at_31", 0, 32'(cnt_o[0]), 32'd31);
    chk("op31_at_31", 0, 32'(op_o[0]), 32'd1);
    chk("c2_at_31", 0, 32'(c2_o[0]), 32'd1);
    step(1, 0, 1, 0);
    chk("fe_first_wrap", 0, 32'(fe_o[0]), 32'd1);
    chk("m1_at_0", 0, 32'(m1_o[0]), 32'd1);
    for (int i = 0; i < 32; i++) step(1, 0, 1, 0);

    // cen every fourth clock.
    for (int i = 0; i < 256; i++) begin
      step((i % 4) == 3, 0, 1, 0);
      if (mcnt == 3 && (i % 4) == 3) begin
        chk("m1_rise_off3", 1, 32'(m1_o[1]), 32'd1);
        chk("ch0_off3",     1, 32'(ch_o[1]), 32'd0);
      end
    end

    // sync mid-frame.
    for (int i = 0; i < 64 && mcnt != 17; i++) step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("sync_cnt0", 0, 32'(cnt_o[0]), 32'd0);
    chk("sync_no_fe", 0, 32'(fe_o[0]), 32'd0);
    for (int i = 0; i < 31; i++) step(1, 0, 1, 0);
    chk("no_fe_before_wrap", 0, 32'(fe_o[0]), 32'd0);
    step(1, 0, 1, 0);
    chk("fe_after_sync_wrap", 0, 32'(fe_o[0]), 32'd1);

    // Sync straight from slot 31 still closes the frame.
    for (int i = 0; i < 64 && mcnt != 31; i++) step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("sync_at_31_fe", 0, 32'(fe_o[0]), 32'd1);

    // Consumer stalls for two frames, then overrun clear.
    step(0, 0, 1, 1);
    for (int i = 0; i < 70; i++) step(1, 0, 0, 0);
    chk("stall_valid", 0, 32'(sv_o[0]), 32'd1);
    chk("stall_overrun", 0, 32'(ov_o[0]), 32'd1);
    step(0, 0, 0, 1);
    chk("clr_overrun", 0, 32'(ov_o[0]), 32'd0);
    chk("clr_keeps_valid", 0, 32'(sv_o[0]), 32'd1);

    // Accept on the same edge as a new frame.
    for (int i = 0; i < 64 && mcnt != 31; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    chk("accept_newframe_valid", 0, 32'(sv_o[0]), 32'd1);
    chk("accept_newframe_ovr", 0, 32'(ov_o[0]), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 40) == 0, $urandom % 2, ($urandom % 8) == 0);

    // Asynchronous reset mid-frame with a pending sample.
    for (int i = 0; i < 100 && !(mcnt == 20 && m_val[0] != 0); i++) step(1, 0, 0, 0);
    chk("pre_reset_valid", 0, 32'(sv_o[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cnt", 0, 32'(cnt_o[0]), 32'd0);
    chk("rst_valid", 0, 32'(sv_o[0]), 32'd0);
    step(1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step(1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jt51_acc_seq.md
Name: jt51_acc_seq

Overview:
Slot sequencer and output scheduler for the channel accumulator. It owns the 32-slot operator cycle (M1, M2, C1, C2 groups of 8 channels). It generates the per-slot group strobes, the op31 noise slot flag and the current channel index that the accumulator and operator pipeline consume. It also raises a frame-complete strobe and carries a valid/ready handshake so a downstream sample consumer (DAC interface, resampler FIFO) can take each finished stereo frame.

Parameters:
OFFSET, 0, pipeline delay in slots between the slot counter and the accumulator input; strobes are derived from (cnt - OFFSET) mod 32, range 0..31
OP31_SLOT, 31, accumulator-aligned slot on which op31_acc is asserted

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cen  input  1  clock enable; all slot state advances only when high
sync  input  1  resynchronise; on a cen cycle forces the slot counter to 0 next
sample_ready  input  1  consumer accepts the pending frame
ovr_clr  input  1  clears the sticky overrun flag
cnt  output  5  current raw slot number 0..31
ch  output  3  channel index of accumulator-aligned slot, acnt[2:0]
m1_enters  output  1  acnt in 0..7
m2_enters  output  1  acnt in 8..15
c1_enters  output  1  acnt in 16..23
c2_enters  output  1  acnt in 24..31
op31_acc  output  1  acnt == OP31_SLOT
frame_end  output  1  one-cen pulse, acnt wrapped 31->0
sample_valid  output  1  a finished frame is pending for the consumer
overrun  output  1  sticky: a frame finished while the previous one was unaccepted

Behaviour:
- Reset, asynchronous, while rst=1: cnt=0 and all strobes computed as for cnt=0 (acnt=(0-OFFSET) mod 32). frame_end=0, sample_valid=0, overrun=0. Release is synchronous to the next clk edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- Slot counter, on clk with cen=1:
  - cnt <= sync ? 0 : cnt+1, wrapping 31->0.
  - cen=0 holds cnt and every strobe unchanged.
- Strobes: on the same edge as the cnt update, the strobe registers load the decode of the next acnt = (next_cnt - OFFSET) mod 32. Strobes are therefore always consistent with the visible cnt.
- Exactly one of m1/m2/c1/c2_enters is high at all times, including during reset.
- frame_end:
  - High for exactly one cen period when the new acnt==0 and the previous acnt==31.
  - A sync that moves acnt off a 31->0 transition produces no frame_end.
  - A sync that jumps from acnt=31 to acnt=0 (OFFSET=0, cnt=31) does produce frame_end.
- Handshake, evaluated every clk edge (not gated by cen) except where frame_end is involved:
  - accept = sample_valid & sample_ready.
  - accept without a new frame: sample_valid <= 0.
  - New frame (cen & next frame_end) with sample_valid=0, or with accept the same edge: sample_valid <= 1, no overrun.
  - New frame with sample_valid=1 and sample_ready=0: sample_valid stays 1, overrun <= 1.
  - ovr_clr=1: overrun <= 0. If overrun set and ovr_clr hit the same edge, set wins.
  - sample_ready is ignored while sample_valid=0.
- Reset mid-frame: everything returns to reset values immediately, and a pending frame is discarded.
- Widths: acnt is a 5-bit subtraction, and modulo wrap is implicit.

Decomposition:
- Shared package jt51_seq_pkg:
  - constants SLOTS=32 and GRP_M1=2'd0, GRP_M2=2'd1, GRP_C1=2'd2, GRP_C2=2'd3
  - a function decoding a 5-bit slot into the one-hot group strobes
- One sub-module, jt51_frame_hs: the valid/ready/overrun handshake register, fed by frame_end_next, sample_ready and ovr_clr.

Test Plan:
- Reset then 64 cen cycles with OFFSET=0:
  - cnt sequence 0..31,0..31
  - m1_enters high for cnt 0..7, c2_enters for 24..31
  - op31_acc only at cnt=31
  - frame_end at cnt=0 of the second frame
- OFFSET=3, cen every 4th clk:
  - m1_enters rises when cnt=3, falls when cnt=11
  - ch=0 at cnt=3
  - nothing changes on cen=0 clocks
- sync asserted at cnt=17:
  - next cnt=0
  - no frame_end that cycle
  - frame_end at the following natural wrap 32 cens later
- sample_ready held 0 for two frames:
  - sample_valid=1 after the first frame_end
  - overrun=1 after the second
  - ovr_clr pulse drops overrun, sample_valid stays 1
- sample_ready=1 on the same edge as a new frame_end: sample_valid remains 1, overrun stays 0.
- rst asserted mid-frame at cnt=20 with sample_valid=1:
  - immediately cnt=0, sample_valid=0, overrun=0
  - after release the sequence restarts from 0
